// File: rtl/mac_rx_rmii_sfd.sv
// RMII receive front end: hunts preamble + SFD, then streams frame dibits
// into a downstream FIFO and reports length/error at the end of each frame.
//
// state | meaning
// IDLE  | carrier off, waiting for first 01 preamble dibit
// PRE   | counting 01 preamble dibits, waiting for the 11 SFD
// DATA  | writing every received dibit to the FIFO
// DROP  | bad/aborted frame, discard until carrier drops
module mac_rx_rmii_sfd #(
    parameter int MIN_PRE   = 4,
    parameter int MAX_BYTES = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        I_crs_dv,
    input  logic [1:0]  I_rxd,
    input  logic        I_fifo_full,
    output logic        O_wr_en,
    output logic [1:0]  O_wr_data,
    output logic        O_frame_end,
    output logic        O_frame_err,
    output logic [10:0] O_frame_len,
    output logic        O_overflow
);

    localparam int              PW         = (MIN_PRE < 2) ? 1 : $clog2(MIN_PRE + 1);
    localparam logic [PW-1:0]   PRE_SAT    = PW'(MIN_PRE);
    localparam logic [12:0]     MAX_DIBITS = 13'(4 * MAX_BYTES);
    localparam logic [10:0]     MAX_LEN    = 11'(MAX_BYTES);

    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

    state_t        state;
    logic [PW-1:0] pre_cnt;
    logic [12:0]   dibit_cnt;
    logic          ovf;
    logic [12:0]   kept_cnt;

    // The write currently presented was refused by the FIFO.
    assign ovf      = O_wr_en & I_fifo_full;
    assign kept_cnt = dibit_cnt - 13'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pre_cnt     <= '0;
            dibit_cnt   <= '0;
            O_wr_en     <= 1'b0;
            O_wr_data   <= 2'b00;
            O_frame_end <= 1'b0;
            O_frame_err <= 1'b0;
            O_frame_len <= '0;
            O_overflow  <= 1'b0;
        end else begin
            O_wr_en     <= 1'b0;
            O_wr_data   <= 2'b00;
            O_frame_end <= 1'b0;
            O_frame_err <= 1'b0;
            O_frame_len <= '0;
            if (ovf) O_overflow <= 1'b1;

            case (state)
                IDLE: begin
                    pre_cnt   <= '0;
                    dibit_cnt <= '0;
                    if (I_crs_dv) begin
                        if (I_rxd == 2'b01) begin
                            state   <= PRE;
                            pre_cnt <= PW'(1);
                        end else begin
                            state <= DROP;
                        end
                    end
                end

                PRE: begin
                    if (!I_crs_dv) begin
                        state   <= IDLE;
                        pre_cnt <= '0;
                    end else begin
                        case (I_rxd)
                            2'b01: if (pre_cnt < PRE_SAT) pre_cnt <= pre_cnt + PW'(1);
                            2'b11: begin
                                if (pre_cnt >= PRE_SAT) begin
                                    state     <= DATA;
                                    dibit_cnt <= '0;
                                end else begin
                                    state <= DROP;
                                end
                            end
                            default: state <= DROP;
                        endcase
                    end
                end

                DATA: begin
                    if (ovf) begin
                        // Covers overflow on the final write too: one pulse, err forced.
                        state       <= DROP;
                        O_frame_end <= 1'b1;
                        O_frame_err <= 1'b1;
                        O_frame_len <= kept_cnt[12:2];
                    end else if (!I_crs_dv) begin
                        state       <= IDLE;
                        pre_cnt     <= '0;
                        dibit_cnt   <= '0;
                        O_frame_end <= 1'b1;
                        O_frame_err <= |dibit_cnt[1:0];
                        O_frame_len <= dibit_cnt[12:2];
                    end else if (dibit_cnt == MAX_DIBITS) begin
                        state       <= DROP;
                        O_frame_end <= 1'b1;
                        O_frame_err <= 1'b1;
                        O_frame_len <= MAX_LEN;
                    end else begin
                        O_wr_en   <= 1'b1;
                        O_wr_data <= I_rxd;
                        dibit_cnt <= dibit_cnt + 13'd1;
                    end
                end

                DROP: begin
                    if (!I_crs_dv) begin
                        state     <= IDLE;
                        pre_cnt   <= '0;
                        dibit_cnt <= '0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
